// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of imem_loader.
// slave: the loader side; master: the stream source / memory side.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: header(N) + 4N little-endian bytes [+ XOR checksum byte].
// Optional checksum stage is compiled in with `define IMEM_LOADER_CSUM_EN.
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    imem_loader_if.slave bus,
    input  logic         reload,
    output logic         cpu_hold,
    output logic         done,
    output logic         error
);

    typedef enum logic [2:0] {
        StHdrLo,
        StHdrHi,
        StData,
`ifdef IMEM_LOADER_CSUM_EN
        StCsum,
`endif
        StDone,
        StErr
    } state_e;

    localparam logic [16:0] DepthLim = 17'(DEPTH_WORDS);

    state_e      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] idx_q, idx_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] word_q, word_d;
    logic        in_ready_q, in_ready_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic        accept;
    logic [15:0] hdr_n;

    assign accept = bus.in_valid && in_ready_q;
    assign hdr_n  = {bus.in_data, count_q[7:0]};

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        in_ready_d = in_ready_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = done_q;
        error_d    = error_q;
`ifdef IMEM_LOADER_CSUM_EN
        csum_d = csum_q;
        if (accept && state_q != StCsum) csum_d = csum_q ^ bus.in_data;
`endif
        case (state_q)
            StHdrLo: begin
                if (accept) begin
                    count_d[7:0] = bus.in_data;
                    state_d      = StHdrHi;
                end
            end
            StHdrHi: begin
                if (accept) begin
                    count_d = hdr_n;
                    if ({1'b0, hdr_n} > DepthLim) begin
                        state_d    = StErr;
                        error_d    = 1'b1;
                        in_ready_d = 1'b0;
                    end else if (hdr_n == 16'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
                        state_d = StCsum;
`else
                        state_d    = StDone;
                        in_ready_d = 1'b0;
`endif
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    if (byte_cnt_q == 2'd3) begin
                        wr_en_d    = 1'b1;
                        wr_data_d  = {bus.in_data, word_q};
                        wr_addr_d  = BASE_ADDR + {14'd0, idx_q, 2'b00};
                        idx_d      = idx_q + 16'd1;
                        byte_cnt_d = 2'd0;
                        if (idx_q == count_q - 16'd1) begin
`ifdef IMEM_LOADER_CSUM_EN
                            state_d = StCsum;
`else
                            state_d    = StDone;
                            in_ready_d = 1'b0;
`endif
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0:    word_d[7:0]   = bus.in_data;
                            2'd1:    word_d[15:8]  = bus.in_data;
                            default: word_d[23:16] = bus.in_data;
                        endcase
                    end
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            StCsum: begin
                if (accept) begin
                    in_ready_d = 1'b0;
                    if (bus.in_data == csum_q) begin
                        state_d    = StDone;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = StErr;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            StDone, StErr: begin
                // Without the checksum stage, release lags the last write by one cycle.
                if (state_q == StDone) begin
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                end
                if (reload) begin
                    state_d    = StHdrLo;
                    in_ready_d = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    cpu_hold_d = 1'b1;
                    count_d    = 16'd0;
                    idx_d      = 16'd0;
                    byte_cnt_d = 2'd0;
`ifdef IMEM_LOADER_CSUM_EN
                    csum_d = 8'd0;
`endif
                end
            end
            default: begin
                state_d    = StHdrLo;
                in_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StHdrLo;
            count_q    <= 16'd0;
            idx_q      <= 16'd0;
            byte_cnt_q <= 2'd0;
            word_q     <= 24'd0;
            in_ready_q <= 1'b1;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= BASE_ADDR;
            wr_data_q  <= 32'd0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q <= csum_d;
`endif
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes are queued as each image is
// built and popped by a write monitor; status outputs are checked at fixed cycle offsets.
module tb_imem_loader;
    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk;
    logic rst_n;
    logic reload;
    logic cpu_hold;
    logic done;
    logic error;

    imem_loader_if bus ();

    imem_loader #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .reload  (reload),
        .cpu_hold(cpu_hold),
        .done    (done),
        .error   (error)
    );

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    logic [31:0] img[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.wr_en === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0)
            else begin
                errors++;
                $error("FAIL unexpected_wr: observed addr %h data %h expected no write",
                       bus.wr_addr, bus.wr_data);
            end
            if (exp_q.size() != 0) begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("wr_addr", bus.wr_addr, e[63:32]);
                check("wr_data", bus.wr_data, e[31:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit throttle);
        logic rdy;
        int   n;
        if (throttle) begin
            repeat ($urandom_range(0, 2)) begin
                bus.in_valid = 1'b0;
                step();
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        do begin
            rdy = bus.in_ready;
            step();
            n++;
        end while (!rdy && n < 16);
        check("byte_accept", {31'd0, rdy}, 32'd1);
    endtask

    // Streams img[] as an image; corrupt flips the checksum byte.
    task automatic load_image(input bit throttle, input bit corrupt);
        logic [7:0]  bytes[$];
        logic [7:0]  x;
        logic [15:0] n;
        logic [31:0] w;
        bit          ok;
        ok = !corrupt;
        n  = 16'(img.size());
        bytes.push_back(n[7:0]);
        bytes.push_back(n[15:8]);
        for (int i = 0; i < img.size(); i++) begin
            w = img[i];
            for (int b = 0; b < 4; b++) bytes.push_back(w[8*b +: 8]);
            exp_q.push_back({BASE + 32'(i * 4), w});
        end
        x = 8'd0;
        foreach (bytes[k]) x = x ^ bytes[k];
        foreach (bytes[k]) send_byte(bytes[k], throttle);
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(corrupt ? (x ^ 8'h01) : x, throttle);
        bus.in_valid = 1'b0;
        check("csum_done", {31'd0, done}, {31'd0, ok});
`else
        bus.in_valid = 1'b0;
        check("done_not_early", {31'd0, done}, 32'd0);
        step();
        check("done_release", {31'd0, done}, 32'd1);
`endif
        @(negedge clk);
        check("sb_empty", exp_q.size(), 32'd0);
        check("end_done", {31'd0, done}, {31'd0, ok});
        check("end_error", {31'd0, error}, {31'd0, !ok});
        check("end_hold", {31'd0, cpu_hold}, {31'd0, !ok});
        check("end_ready", {31'd0, bus.in_ready}, 32'd0);
        step();
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        step();
        reload = 1'b0;
        check("reload_ready", {31'd0, bus.in_ready}, 32'd1);
        check("reload_done", {31'd0, done}, 32'd0);
        check("reload_err", {31'd0, error}, 32'd0);
        check("reload_hold", {31'd0, cpu_hold}, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wr_en"}, {31'd0, bus.wr_en}, 32'd0);
        check({tag, "_wr_addr"}, bus.wr_addr, BASE);
        check({tag, "_wr_data"}, bus.wr_data, 32'd0);
        check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd1);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        reload       = 1'b0;
        rst_n        = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        check_reset_values("rst");

        // Nominal two-word image, back-to-back bytes.
        img = '{32'h0000_0013, 32'h0050_0093};
        load_image(1'b0, 1'b0);
        pulse_reload();

        // Same image with random gaps mid-header and mid-word.
        load_image(1'b1, 1'b0);
        pulse_reload();

`ifdef IMEM_LOADER_CSUM_EN
        load_image(1'b0, 1'b1);
        pulse_reload();
`endif

        // Oversize header: N = 257.
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        bus.in_valid = 1'b0;
        check("ovf_error", {31'd0, error}, 32'd1);
        repeat (5) step();
        check("ovf_error_hold", {31'd0, error}, 32'd1);
        check("ovf_ready", {31'd0, bus.in_ready}, 32'd0);
        check("ovf_hold", {31'd0, cpu_hold}, 32'd1);
        pulse_reload();

        // Reset in the middle of a word; outputs must clear without a clock edge.
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hEF, 1'b0);
        send_byte(8'hBE, 1'b0);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_rst");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        img = '{32'hDEAD_BEEF};
        load_image(1'b0, 1'b0);
        pulse_reload();

        // Zero-length image.
        img = {};
        load_image(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
